ysyx_041461_div_ctrl: RTL and testbench
=======================================

// Module: ysyx_041461_div_ctrl
// PURPOSE
//   Execute-stage initiator for the iterative divider (ysyx_041461_DIV). Accepts RV64M
//   DIV/DIVU/REM/REMU[W] requests, resolves divide-by-zero and signed overflow locally,
//   otherwise issues one request to the divider and waits for its completion pulse.
//   Selects quotient or remainder, applies 32-bit sign extension for W ops, and holds
//   the result until writeback accepts it.
// PARAMETERS
//   XLEN     64   operand/result width; fixed at 64 for the divider interface
// PORTS
//   clk            in   1     core clock
//   rst            in   1     asynchronous reset, active-low (0 = reset)
//   flush          in   1     kill the in-flight op; result is never presented
//   req_valid      in   1     request present this cycle
//   req_ready      out  1     controller can accept (state IDLE)
//   req_op         in   2     0 DIV, 1 DIVU, 2 REM, 3 REMU
//   req_word       in   1     W variant: operands are bits [31:0], result sign-extended
//   req_src1       in   64    dividend
//   req_src2       in   64    divisor
//   res_valid      out  1     result held (state DONE)
//   res_ready      in   1     writeback consumes result
//   res_data       out  64    final rd value
//   DIV_valid_in   out  1     one-cycle start pulse to divider
//   DIV_signed     out  1     signed divide (op 0/2)
//   DIV_divw       out  1     32-bit divide
//   DIV_dividend   out  64    W: sign/zero-extended src1[31:0] per signedness; else src1
//   DIV_divisor    out  64    same rule on src2
//   DIV_valid_out  in   1     divider done; meaningful only in WAIT/DRAIN
//   DIV_quotient   in   64    divider quotient
//   DIV_remainder  in   64    divider remainder
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1, res_valid=0, res_data=0, DIV_valid_in=0, all DIV_* data 0.
//   - All outputs registered except req_ready/res_valid (decoded from state).
//   - IDLE: on req_valid, latch op/word/operands. Special case -> DONE next cycle with
//     computed result (1-cycle latency). Else -> ISSUE.
//   - Special cases (on effective operands, width W=32 or 64): divisor==0 -> quot=all ones,
//     rem=dividend. Signed and dividend==min_int(W) and divisor==-1 -> quot=dividend, rem=0.
//   - ISSUE: DIV_valid_in=1 for exactly this cycle, DIV_* data stable from ISSUE until
//     leaving WAIT. -> WAIT.
//   - WAIT: DIV_valid_out ignored in ISSUE cycle; first DIV_valid_out in WAIT captures
//     quotient (op 0/1) or remainder (op 2/3) -> DONE.
//   - W result: res_data = {{32{r[31]}}, r[31:0]} for every W op, special or not.
//   - DONE: res_valid=1, res_data stable until res_valid&&res_ready -> IDLE. No new req
//     accepted in the same cycle (req_ready low).
//   - flush: IDLE no effect; ISSUE/WAIT -> DRAIN (divider cannot abort); DONE -> IDLE,
//     result dropped. flush with DIV_valid_out in same WAIT cycle -> IDLE, result dropped.
//   - DRAIN: req_ready=0, res_valid=0; on DIV_valid_out -> IDLE, result discarded.
//   - flush and req_valid in IDLE same cycle: request ignored.
//   - Reset mid-operation: immediate return to IDLE; any later DIV_valid_out ignored.
// STRUCTURE
//   - Shared package: div op encodings (DIV/DIVU/REM/REMU), state enum
//     {IDLE, ISSUE, WAIT, DONE, DRAIN}, XLEN constant.
//   - One sub-module: ysyx_041461_div_special (combinational: effective operand
//     extension, zero/overflow detection, special-case result); FSM stays in top.
// TESTING
//   - DIV 64: src1=-7, src2=2, divider returns q=-3 -> res_data=0xFFFF_FFFF_FFFF_FFFD; one DIV_valid_in pulse.
//   - REMU by zero: src1=0x1234, src2=0 -> res_valid 1 cycle after accept, res_data=0x1234, DIV_valid_in never high.
//   - DIVW overflow: src1=0x8000_0000, src2=0xFFFF_FFFF -> res_data=0xFFFF_FFFF_8000_0000, no divider issue.
//   - DIVUW: src1=0xFFFF_FFFF, src2=1, q=0xFFFF_FFFF -> res_data=0xFFFF_FFFF_FFFF_FFFF; DIV_dividend zero-extended.
//   - flush in WAIT, divider done 5 cycles later -> res_valid never 1, req_ready returns after DIV_valid_out.
//   - res_ready held 0 for 10 cycles in DONE -> res_data stable, req_ready 0; rst low mid-WAIT -> IDLE.

Source files
------------

// File: rtl/ysyx_041461_div_ctrl_pkg.sv
// Shared types for the divider controller: op encodings, FSM states, result formatting.
package ysyx_041461_div_ctrl_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } div_state_e;

  // W ops always write back the low word sign-extended, even for unsigned variants.
  function automatic logic [XLEN-1:0] fmt_result(input logic word, input logic [XLEN-1:0] r);
    return word ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
  endfunction

endpackage

// File: rtl/ysyx_041461_div_ctrl_if.sv
// Request/result handshake plus divider start/completion bus; master is the controller.
interface ysyx_041461_div_ctrl_if;
  import ysyx_041461_div_ctrl_pkg::*;

  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic            DIV_valid_in;
  logic            DIV_signed;
  logic            DIV_divw;
  logic [XLEN-1:0] DIV_dividend;
  logic [XLEN-1:0] DIV_divisor;
  logic            DIV_valid_out;
  logic [XLEN-1:0] DIV_quotient;
  logic [XLEN-1:0] DIV_remainder;

  modport master (
    input  flush, req_valid, req_op, req_word, req_src1, req_src2, res_ready,
           DIV_valid_out, DIV_quotient, DIV_remainder,
    output req_ready, res_valid, res_data,
           DIV_valid_in, DIV_signed, DIV_divw, DIV_dividend, DIV_divisor
  );

  modport slave (
    output flush, req_valid, req_op, req_word, req_src1, req_src2, res_ready,
           DIV_valid_out, DIV_quotient, DIV_remainder,
    input  req_ready, res_valid, res_data,
           DIV_valid_in, DIV_signed, DIV_divw, DIV_dividend, DIV_divisor
  );

endinterface

// File: rtl/ysyx_041461_div_special.sv
// Combinational operand extension and divide-by-zero / signed-overflow resolution.
// Zero and overflow are evaluated on the extended operands, so W ops use 32-bit limits.
module ysyx_041461_div_special
  import ysyx_041461_div_ctrl_pkg::*;
(
  input  div_op_e         op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            is_signed,
  output logic            sel_rem,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic            special,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] min_int;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic            div_zero;
  logic            overflow;

  always_comb begin
    is_signed = (op == OP_DIV) || (op == OP_REM);
    sel_rem   = (op == OP_REM) || (op == OP_REMU);

    if (word) begin
      dividend = is_signed ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]};
      divisor  = is_signed ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]};
      min_int  = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end else begin
      dividend = src1;
      divisor  = src2;
      min_int  = {1'b1, {(XLEN-1){1'b0}}};
    end

    div_zero = (divisor == '0);
    overflow = is_signed && (dividend == min_int) && (divisor == '1);
    special  = div_zero || overflow;

    quot = '1;
    rem  = dividend;
    if (overflow) begin
      quot = dividend;
      rem  = '0;
    end
    result = fmt_result(word, sel_rem ? rem : quot);
  end

endmodule

// File: rtl/ysyx_041461_div_ctrl.sv
// Divider initiator: special cases finish 1 cycle after accept, others issue one pulse and wait.
// Result is held in DONE until res_ready; req_ready only in IDLE, so no accept overlaps a held result.
module ysyx_041461_div_ctrl
  import ysyx_041461_div_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  ysyx_041461_div_ctrl_if.master bus
);

  div_state_e      state_q, state_d;
  logic            sel_rem_q, sel_rem_d;
  logic [XLEN-1:0] res_data_q, res_data_d;
  logic            div_valid_in_q, div_valid_in_d;
  logic            div_signed_q, div_signed_d;
  logic            div_divw_q, div_divw_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;

  logic            sp_signed;
  logic            sp_rem;
  logic [XLEN-1:0] sp_dividend;
  logic [XLEN-1:0] sp_divisor;
  logic            sp_special;
  logic [XLEN-1:0] sp_result;

  ysyx_041461_div_special u_special (
    .op        (div_op_e'(bus.req_op)),
    .word      (bus.req_word),
    .src1      (bus.req_src1),
    .src2      (bus.req_src2),
    .is_signed (sp_signed),
    .sel_rem   (sp_rem),
    .dividend  (sp_dividend),
    .divisor   (sp_divisor),
    .special   (sp_special),
    .result    (sp_result)
  );

  always_comb begin
    state_d        = state_q;
    sel_rem_d      = sel_rem_q;
    res_data_d     = res_data_q;
    div_valid_in_d = 1'b0;
    div_signed_d   = div_signed_q;
    div_divw_d     = div_divw_q;
    dividend_d     = dividend_q;
    divisor_d      = divisor_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          sel_rem_d = sp_rem;
          if (sp_special) begin
            res_data_d = sp_result;
            state_d    = DONE;
          end else begin
            div_valid_in_d = 1'b1;
            div_signed_d   = sp_signed;
            div_divw_d     = bus.req_word;
            dividend_d     = sp_dividend;
            divisor_d      = sp_divisor;
            state_d        = ISSUE;
          end
        end
      end
      // A completion seen during ISSUE cannot belong to this request.
      ISSUE: state_d = bus.flush ? DRAIN : WAIT;
      WAIT: begin
        if (bus.flush) begin
          state_d = bus.DIV_valid_out ? IDLE : DRAIN;
        end else if (bus.DIV_valid_out) begin
          res_data_d = fmt_result(div_divw_q, sel_rem_q ? bus.DIV_remainder : bus.DIV_quotient);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.flush || bus.res_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (bus.DIV_valid_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      sel_rem_q      <= 1'b0;
      res_data_q     <= '0;
      div_valid_in_q <= 1'b0;
      div_signed_q   <= 1'b0;
      div_divw_q     <= 1'b0;
      dividend_q     <= '0;
      divisor_q      <= '0;
    end else begin
      state_q        <= state_d;
      sel_rem_q      <= sel_rem_d;
      res_data_q     <= res_data_d;
      div_valid_in_q <= div_valid_in_d;
      div_signed_q   <= div_signed_d;
      div_divw_q     <= div_divw_d;
      dividend_q     <= dividend_d;
      divisor_q      <= divisor_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.res_valid    = (state_q == DONE);
  assign bus.res_data     = res_data_q;
  assign bus.DIV_valid_in = div_valid_in_q;
  assign bus.DIV_signed   = div_signed_q;
  assign bus.DIV_divw     = div_divw_q;
  assign bus.DIV_dividend = dividend_q;
  assign bus.DIV_divisor  = divisor_q;

endmodule

// File: tb/tb_ysyx_041461_div_ctrl.sv
// Randomized bench for the divider controller; the bench also plays the iterative divider.
module tb_ysyx_041461_div_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;
  int   issue_cnt;

  ysyx_041461_div_ctrl_if bus ();

  ysyx_041461_div_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.DIV_valid_in === 1'b1) issue_cnt++;

  // Architectural RV64M result, computed at the operation's own width.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input bit word,
                                          input logic [63:0] a, input logic [63:0] b);
    bit               sgn;
    bit               rem;
    int               sx, sy, st;
    int unsigned      ux, uy, ut;
    longint           lx, ly, lt;
    longint unsigned  vx, vy, vt;
    logic [63:0]      res;
    sgn = (op == 2'd0) || (op == 2'd2);
    rem = (op == 2'd2) || (op == 2'd3);
    if (word && sgn) begin
      sx = a[31:0]; sy = b[31:0];
      if (sy == 0) st = rem ? sx : -1;
      else if (a[31:0] == 32'h8000_0000 && sy == -1) st = rem ? 0 : sx;
      else st = rem ? sx % sy : sx / sy;
      res = {{32{st[31]}}, st};
    end else if (word) begin
      ux = a[31:0]; uy = b[31:0];
      if (uy == 0) ut = rem ? ux : 32'hFFFF_FFFF;
      else ut = rem ? ux % uy : ux / uy;
      res = {{32{ut[31]}}, ut};
    end else if (sgn) begin
      lx = a; ly = b;
      if (ly == 0) lt = rem ? lx : -1;
      else if (a == 64'h8000_0000_0000_0000 && ly == -1) lt = rem ? 0 : lx;
      else lt = rem ? lx % ly : lx / ly;
      res = lt;
    end else begin
      vx = a; vy = b;
      if (vy == 0) vt = rem ? vx : 64'hFFFF_FFFF_FFFF_FFFF;
      else vt = rem ? vx % vy : vx / vy;
      res = vt;
    end
    return res;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'd1;
      2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      3:       v = 64'h8000_0000_0000_0000;
      4:       v = 64'h0000_0000_8000_0000;
      5:       v = {32'h1234_5678, 32'hFFFF_FFFF};
      6:       v = {$urandom(), 32'h0};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic drive_req(input logic [1:0] op, input bit word,
                           input logic [63:0] a, input logic [63:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_word  = word;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_src1  = {$urandom(), $urandom()};
    bus.req_src2  = {$urandom(), $urandom()};
  endtask

  // Full transaction: accept, optional divider round-trip after lat WAIT cycles, hold, drain.
  task automatic do_op(input logic [1:0] op, input bit word, input logic [63:0] a,
                       input logic [63:0] b, input int lat, input int hold);
    logic [63:0] exp_res, ea, eb, q, r;
    bit          sgn, spec;
    int          c0;
    sgn     = (op == 2'd0) || (op == 2'd2);
    exp_res = ref_res(op, word, a, b);
    ea = !word ? a : sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
    eb = !word ? b : sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
    if (word) spec = (b[31:0] == 0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else      spec = (b == 0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
    c0 = issue_cnt;
    vectors++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got=%b want=1", bus.req_ready); end
    drive_req(op, word, a, b);
    if (!spec) begin
      vectors++;
      if (bus.DIV_valid_in !== 1'b1 || bus.DIV_dividend !== ea || bus.DIV_divisor !== eb ||
          bus.DIV_signed !== sgn || bus.DIV_divw !== word || bus.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL issue_bus vin=%b dd=%h ds=%h s=%b w=%b want dd=%h ds=%h s=%b w=%b",
                 bus.DIV_valid_in, bus.DIV_dividend, bus.DIV_divisor, bus.DIV_signed, bus.DIV_divw,
                 ea, eb, sgn, word);
      end
      if (sgn) begin q = $signed(ea) / $signed(eb); r = $signed(ea) % $signed(eb); end
      else     begin q = ea / eb; r = ea % eb; end
      @(posedge clk); #1;
      repeat (lat) begin
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.DIV_valid_in !== 1'b0 || bus.DIV_dividend !== ea) begin
          errors++;
          $display("FAIL wait_state res_valid=%b vin=%b dd=%h want 0 0 %h",
                   bus.res_valid, bus.DIV_valid_in, bus.DIV_dividend, ea);
        end
        @(posedge clk); #1;
      end
      bus.DIV_valid_out = 1'b1;
      bus.DIV_quotient  = q;
      bus.DIV_remainder = r;
      @(posedge clk); #1;
      bus.DIV_valid_out = 1'b0;
      bus.DIV_quotient  = {$urandom(), $urandom()};
      bus.DIV_remainder = {$urandom(), $urandom()};
    end
    vectors++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== exp_res || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL result op=%0d w=%0b a=%h b=%h got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
               op, word, a, b, bus.res_valid, bus.res_data, bus.req_ready, exp_res);
    end
    vectors++;
    if (issue_cnt - c0 != (spec ? 0 : 1)) begin
      errors++; $display("FAIL issue_pulses got=%0d want=%0d", issue_cnt - c0, spec ? 0 : 1);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_res || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold v=%b d=%h rdy=%b want 1 %h 0", bus.res_valid, bus.res_data, bus.req_ready, exp_res);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL release v=%b rdy=%b want 0 1", bus.res_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 64'd0 ||
        bus.DIV_valid_in !== 1'b0 || bus.DIV_signed !== 1'b0 || bus.DIV_divw !== 1'b0 ||
        bus.DIV_dividend !== 64'd0 || bus.DIV_divisor !== 64'd0) begin
      errors++;
      $display("FAIL reset rdy=%b v=%b d=%h vin=%b s=%b w=%b dd=%h ds=%h want 1 0 0 0 0 0 0 0",
               bus.req_ready, bus.res_valid, bus.res_data, bus.DIV_valid_in, bus.DIV_signed,
               bus.DIV_divw, bus.DIV_dividend, bus.DIV_divisor);
    end
  endtask

  task automatic test_directed();
    do_op(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2, 1);
    do_op(2'd3, 1'b0, 64'h1234, 64'd0, 0, 1);
    do_op(2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 1);
    do_op(2'd1, 1'b1, 64'hFFFF_FFFF, 64'd1, 1, 10);
    do_op(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
            $urandom_range(0, 4), $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
            {32'h0, $urandom()} | 64'd3, 0, 0);
  endtask

  task automatic test_issue_ignore();
    drive_req(2'd1, 1'b0, 64'd100, 64'd7);
    bus.DIV_valid_out = 1'b1;
    bus.DIV_quotient  = 64'hDEAD;
    @(posedge clk); #1;
    bus.DIV_valid_out = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL issue_ignore v=%b want 0", bus.res_valid); end
    bus.DIV_valid_out = 1'b1;
    bus.DIV_quotient  = 64'd14;
    @(posedge clk); #1;
    bus.DIV_valid_out = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd14) begin
      errors++; $display("FAIL issue_ignore_res v=%b d=%h want 1 %h", bus.res_valid, bus.res_data, 64'd14);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_flush_wait();
    drive_req(2'd0, 1'b0, 64'd1000, 64'd3);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.req_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
        errors++; $display("FAIL drain cyc=%0d rdy=%b v=%b want 0 0", i, bus.req_ready, bus.res_valid);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    bus.DIV_valid_out = 1'b1;
    @(posedge clk); #1;
    bus.DIV_valid_out = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL drain_exit rdy=%b v=%b want 1 0", bus.req_ready, bus.res_valid);
    end
  endtask

  task automatic test_flush_misc();
    // flush during ISSUE still has to drain the divider
    drive_req(2'd2, 1'b0, 64'd50, 64'd9);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_issue rdy=%b v=%b want 0 0", bus.req_ready, bus.res_valid);
    end
    bus.DIV_valid_out = 1'b1;
    @(posedge clk); #1;
    bus.DIV_valid_out = 1'b0;
    // flush coinciding with completion in WAIT
    drive_req(2'd0, 1'b0, 64'd77, 64'd5);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.DIV_valid_out = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.DIV_valid_out = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_done_same rdy=%b v=%b want 1 0", bus.req_ready, bus.res_valid);
    end
    // flush while a special-case result is held
    drive_req(2'd3, 1'b0, 64'h55, 64'd0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_in_done rdy=%b v=%b want 1 0", bus.req_ready, bus.res_valid);
    end
    // flush and request in the same IDLE cycle
    bus.flush = 1'b1;
    drive_req(2'd1, 1'b0, 64'd40, 64'd6);
    bus.flush = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.DIV_valid_in !== 1'b0) begin
      errors++; $display("FAIL flush_idle rdy=%b v=%b vin=%b want 1 0 0", bus.req_ready, bus.res_valid, bus.DIV_valid_in);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive_req(2'd0, 1'b0, 64'd900, 64'd11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.DIV_dividend !== 64'd0) begin
      errors++; $display("FAIL rst_mid rdy=%b v=%b dd=%h want 1 0 0", bus.req_ready, bus.res_valid, bus.DIV_dividend);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.DIV_valid_out = 1'b1;
    bus.DIV_quotient  = 64'd81;
    @(posedge clk); #1;
    bus.DIV_valid_out = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL rst_late_done rdy=%b v=%b want 1 0", bus.req_ready, bus.res_valid);
    end
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    issue_cnt = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 2'd0;
    bus.req_word = 1'b0;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    bus.res_ready = 1'b0;
    bus.DIV_valid_out = 1'b0;
    bus.DIV_quotient = '0;
    bus.DIV_remainder = '0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_directed();
    test_issue_ignore();
    test_flush_wait();
    test_flush_misc();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
